// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write side: default geometry,
// MIPI-DCS opcodes understood by the writer, and the command FSM encoding.
package fb_pkg;

    localparam int FB_H_DEF   = 480;
    localparam int FB_V_DEF   = 320;
    localparam int ADDR_W_DEF = 18;

    localparam logic [7:0] DCS_CASET = 8'h2A;
    localparam logic [7:0] DCS_PASET = 8'h2B;
    localparam logic [7:0] DCS_RAMWR = 8'h2C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CASET = 2'd1,
        ST_PASET = 2'd2,
        ST_RAMWR = 2'd3
    } fbw_state_t;

endpackage

// File: rtl/fbw_addr_calc.sv
// Linear framebuffer address row*FB_H + col, truncated to ADDR_W.
// The 480-pixel-wide frame uses row*512 - row*32 so no multiplier is needed;
// any other width falls back to a generic multiply.
module fbw_addr_calc
    import fb_pkg::*;
#(
    parameter int FB_H   = FB_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [15:0]       row,
    input  logic [15:0]       col,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] row_w;
    logic [ADDR_W-1:0] col_w;

    assign row_w = ADDR_W'(row);
    assign col_w = ADDR_W'(col);

    generate
        if (FB_H == 480) begin : g_shift_add
            assign addr = (row_w << 9) - (row_w << 5) + col_w;
        end else begin : g_mul
            assign addr = row_w * ADDR_W'(FB_H) + col_w;
        end
    endgenerate

endmodule

// File: rtl/framebuffer_writer.sv
// Write side of the RGB565 framebuffer: decodes the host DCS byte stream
// (CASET / PASET / RAMWR) into registered RAM write beats.
// Optional build macro FB_WRITER_CLIP_EN suppresses writes for pixels
// outside the FB_H x FB_V frame while the window position keeps advancing.
module framebuffer_writer
    import fb_pkg::*;
#(
    parameter int FB_H   = FB_H_DEF,
    parameter int FB_V   = FB_V_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_dc,
    input  logic [7:0]        i_data,
    output logic [ADDR_W-1:0] o_write_address,
    output logic [15:0]       o_write_data,
    output logic              o_write_enable,
    output logic              o_ramwr_active
);

    fbw_state_t        state, state_nxt;
    logic              cmd_beat, dat_beat, param_beat, pix_beat, in_frame;
    logic [15:0]       sc, ec, sp, ep;
    logic [15:0]       col, row;
    logic [1:0]        pidx;
    logic [23:0]       par_buf;
    logic              phase;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] pix_addr;
    logic              wr_vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [15:0]       wr_data_p1;

    assign cmd_beat   = i_valid & ~i_dc;
    assign dat_beat   = i_valid & i_dc;
    assign param_beat = dat_beat && ((state == ST_CASET) || (state == ST_PASET));
    assign pix_beat   = dat_beat && (state == ST_RAMWR) && phase;

`ifdef FB_WRITER_CLIP_EN
    assign in_frame = (col < 16'(FB_H)) && (row < 16'(FB_V));
`else
    localparam logic FRAME_NONEMPTY = (FB_H > 0) && (FB_V > 0);
    assign in_frame = FRAME_NONEMPTY;
`endif

    fbw_addr_calc #(
        .FB_H   (FB_H),
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .row  (row),
        .col  (col),
        .addr (pix_addr)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next state: any command byte re-decodes; the 4th window parameter returns to idle
    always_comb begin
        state_nxt = state;
        if (cmd_beat) begin
            case (i_data)
                DCS_CASET: state_nxt = ST_CASET;
                DCS_PASET: state_nxt = ST_PASET;
                DCS_RAMWR: state_nxt = ST_RAMWR;
                default:   state_nxt = ST_IDLE;
            endcase
        end else if (param_beat && (pidx == 2'd3)) begin
            state_nxt = ST_IDLE;
        end
    end

    // Window parameters: collect three bytes, commit start/end together on the fourth
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sc      <= 16'd0;
            ec      <= 16'(FB_H - 1);
            sp      <= 16'd0;
            ep      <= 16'(FB_V - 1);
            pidx    <= 2'd0;
            par_buf <= 24'd0;
        end else if (cmd_beat) begin
            pidx <= 2'd0;
        end else if (param_beat) begin
            pidx <= pidx + 2'd1;
            case (pidx)
                2'd0: par_buf[23:16] <= i_data;
                2'd1: par_buf[15:8]  <= i_data;
                2'd2: par_buf[7:0]   <= i_data;
                default: begin
                    if (state == ST_CASET) begin
                        sc <= par_buf[23:8];
                        ec <= {par_buf[7:0], i_data};
                    end else begin
                        sp <= par_buf[23:8];
                        ep <= {par_buf[7:0], i_data};
                    end
                end
            endcase
        end
    end

    // Pixel byte phase and window position; advance after each completed pixel
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col     <= 16'd0;
            row     <= 16'd0;
            phase   <= 1'b0;
            hi_byte <= 8'd0;
        end else if (cmd_beat) begin
            phase <= 1'b0;
            if (i_data == DCS_RAMWR) begin
                col <= sc;
                row <= sp;
            end
        end else if (dat_beat && (state == ST_RAMWR)) begin
            if (!phase) begin
                hi_byte <= i_data;
                phase   <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (col == ec) begin
                    col <= sc;
                    row <= (row == ep) ? sp : row + 16'd1;
                end else begin
                    col <= col + 16'd1;
                end
            end
        end
    end

    // Stage p1: registered write beat, one cycle after the second pixel byte
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= 16'd0;
        end else begin
            wr_vld_p1 <= pix_beat && in_frame;
            if (pix_beat) begin
                wr_addr_p1 <= pix_addr;
                wr_data_p1 <= {hi_byte, i_data};
            end
        end
    end

    assign o_write_enable  = wr_vld_p1;
    assign o_write_address = wr_addr_p1;
    assign o_write_data    = wr_data_p1;
    assign o_ramwr_active  = (state == ST_RAMWR);

endmodule

// File: tb/tb_framebuffer_writer.sv
// Self-checking bench for framebuffer_writer: a window/pixel model predicts
// the write beat and RAMWR flag for every cycle; directed tests pin literals.
module tb_framebuffer_writer;

    localparam int M_IDLE = 0, M_CASET = 1, M_PASET = 2, M_RAMWR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        dc = 1'b0;
    logic [7:0]  data = 8'd0;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        ramwr_active;

    int tests = 0;
    int fails = 0;

    // model state
    int m_st, m_sc, m_ec, m_sp, m_ep, m_col, m_row, m_pidx, m_half, m_hi;
    int m_par[4];
    logic        nxt_we, nxt_active, exp_we, exp_active;
    logic [17:0] nxt_addr, exp_addr;
    logic [15:0] nxt_data, exp_data;
    logic        run_cmp = 1'b0;

    logic [17:0] cap_a[$];
    logic [15:0] cap_d[$];

    framebuffer_writer dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_valid         (valid),
        .i_dc            (dc),
        .i_data          (data),
        .o_write_address (wr_addr),
        .o_write_data    (wr_data),
        .o_write_enable  (wr_en),
        .o_ramwr_active  (ramwr_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic bit pixel_visible(input int c, input int r);
`ifdef FB_WRITER_CLIP_EN
        return (c < 480) && (r < 320);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_sc = 0; m_ec = 479; m_sp = 0; m_ep = 319;
        m_col = 0; m_row = 0; m_pidx = 0; m_half = 0; m_hi = 0;
        nxt_we = 1'b0; nxt_active = 1'b0; nxt_addr = '0; nxt_data = '0;
    endtask

    // Effect of one host byte on the model; sets the outputs expected next cycle
    task automatic model_byte(input logic d, input logic [7:0] b);
        nxt_we = 1'b0;
        if (!d) begin
            m_pidx = 0;
            m_half = 0;
            if (b == 8'h2A)      m_st = M_CASET;
            else if (b == 8'h2B) m_st = M_PASET;
            else if (b == 8'h2C) begin m_st = M_RAMWR; m_col = m_sc; m_row = m_sp; end
            else                 m_st = M_IDLE;
        end else if (m_st == M_CASET || m_st == M_PASET) begin
            m_par[m_pidx] = int'(b);
            if (m_pidx == 3) begin
                if (m_st == M_CASET) begin
                    m_sc = m_par[0] * 256 + m_par[1];
                    m_ec = m_par[2] * 256 + m_par[3];
                end else begin
                    m_sp = m_par[0] * 256 + m_par[1];
                    m_ep = m_par[2] * 256 + m_par[3];
                end
                m_pidx = 0;
                m_st = M_IDLE;
            end else begin
                m_pidx++;
            end
        end else if (m_st == M_RAMWR) begin
            if (m_half == 0) begin
                m_hi = int'(b);
                m_half = 1;
            end else begin
                m_half = 0;
                nxt_we = pixel_visible(m_col, m_row);
                nxt_addr = 18'((m_row * 480 + m_col) % 262144);
                nxt_data = 16'(m_hi * 256 + int'(b));
                if (m_col == m_ec) begin
                    m_col = m_sc;
                    m_row = (m_row == m_ep) ? m_sp : (m_row + 1) % 65536;
                end else begin
                    m_col = (m_col + 1) % 65536;
                end
            end
        end
        nxt_active = (m_st == M_RAMWR);
    endtask

    // Expected outputs move to the "visible" slot on each clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_we = 1'b0; exp_active = 1'b0; exp_addr = '0; exp_data = '0;
        end else begin
            exp_we = nxt_we; exp_active = nxt_active;
            exp_addr = nxt_addr; exp_data = nxt_data;
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("write_enable", int'(wr_en), int'(exp_we));
            chk("ramwr_active", int'(ramwr_active), int'(exp_active));
            if (exp_we) begin
                chk("write_address", int'(wr_addr), int'(exp_addr));
                chk("write_data", int'(wr_data), int'(exp_data));
            end
            if (wr_en) begin
                cap_a.push_back(wr_addr);
                cap_d.push_back(wr_data);
            end
        end
    end

    // Drive one byte for exactly one cycle (called just after a rising edge)
    task automatic send(input logic d, input logic [7:0] b);
        valid = 1'b1; dc = d; data = b;
        model_byte(d, b);
        @(posedge clk); #1;
        valid = 1'b0; dc = 1'b0; data = 8'd0;
        nxt_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        cap_a.delete();
        cap_d.delete();
    endtask

    task automatic send_window(input logic [7:0] op, input int s, input int e);
        send(1'b0, op);
        send(1'b1, 8'(s >> 8)); send(1'b1, 8'(s));
        send(1'b1, 8'(e >> 8)); send(1'b1, 8'(e));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        chk("reset_we", int'(wr_en), 0);
        chk("reset_addr", int'(wr_addr), 0);
        chk("reset_data", int'(wr_data), 0);
        chk("reset_active", int'(ramwr_active), 0);
        run_cmp = 1'b1;

        // Test 1: two pixels from reset window, write one cycle after 2nd byte
        do_reset();
        send(1'b0, 8'h2C);
        chk("t1_active", int'(ramwr_active), 1);
        send(1'b1, 8'hF8);
        chk("t1_no_write_half", int'(wr_en), 0);
        send(1'b1, 8'h00);
        chk("t1_we_latency", int'(wr_en), 1);
        send(1'b1, 8'h07);
        send(1'b1, 8'hE0);
        send(1'b0, 8'h00);
        idle(2);
        chk("t1_count", cap_a.size(), 2);
        if (cap_a.size() == 2) begin
            chk("t1_addr0", int'(cap_a[0]), 0);
            chk("t1_data0", int'(cap_d[0]), 16'hF800);
            chk("t1_addr1", int'(cap_a[1]), 1);
            chk("t1_data1", int'(cap_d[1]), 16'h07E0);
        end

        // Test 2: 2x2 window with wrap back to the start
        do_reset();
        send_window(8'h2A, 10, 11);
        send_window(8'h2B, 5, 6);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 8'h00);
            send(1'b1, 8'(i + 1));
        end
        idle(2);
        chk("t2_count", cap_a.size(), 5);
        if (cap_a.size() == 5) begin
            chk("t2_addr0", int'(cap_a[0]), 2410);
            chk("t2_addr1", int'(cap_a[1]), 2411);
            chk("t2_addr2", int'(cap_a[2]), 2890);
            chk("t2_addr3", int'(cap_a[3]), 2891);
            chk("t2_addr4", int'(cap_a[4]), 2410);
            chk("t2_data4", int'(cap_d[4]), 5);
        end

        // Test 3: half pixel discarded by an unknown command
        do_reset();
        send(1'b0, 8'h2C);
        send(1'b1, 8'hAA);
        send(1'b0, 8'h00);
        chk("t3_idle_active", int'(ramwr_active), 0);
        send(1'b0, 8'h2C);
        send(1'b1, 8'h12);
        send(1'b1, 8'h34);
        idle(2);
        chk("t3_count", cap_a.size(), 1);
        if (cap_a.size() == 1) begin
            chk("t3_addr", int'(cap_a[0]), 0);
            chk("t3_data", int'(cap_d[0]), 16'h1234);
        end

        // Test 4: truncated CASET leaves the window untouched
        do_reset();
        send(1'b0, 8'h2A);
        send(1'b1, 8'h00);
        send(1'b1, 8'h10);
        send(1'b0, 8'h2C);
        send(1'b1, 8'hAB);
        send(1'b1, 8'hCD);
        send(1'b1, 8'h11);
        send(1'b1, 8'h22);
        idle(2);
        chk("t4_count", cap_a.size(), 2);
        if (cap_a.size() == 2) begin
            chk("t4_addr0", int'(cap_a[0]), 0);
            chk("t4_data0", int'(cap_d[0]), 16'hABCD);
            chk("t4_addr1", int'(cap_a[1]), 1);
        end

        // Test 5: window straddling the right edge of the frame
        do_reset();
        send_window(8'h2A, 479, 480);
        send(1'b0, 8'h2C);
        send(1'b1, 8'h55); send(1'b1, 8'h66);
        send(1'b1, 8'h77); send(1'b1, 8'h88);
        idle(2);
`ifdef FB_WRITER_CLIP_EN
        chk("t5_count", cap_a.size(), 1);
        if (cap_a.size() >= 1) chk("t5_addr0", int'(cap_a[0]), 479);
`else
        chk("t5_count", cap_a.size(), 2);
        if (cap_a.size() == 2) begin
            chk("t5_addr0", int'(cap_a[0]), 479);
            chk("t5_addr1", int'(cap_a[1]), 480);
            chk("t5_data1", int'(cap_d[1]), 16'h7788);
        end
`endif

        // Test 6: asynchronous reset in the middle of a pixel
        do_reset();
        send_window(8'h2A, 100, 200);
        send(1'b0, 8'h2C);
        send(1'b1, 8'hF0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_active_in_reset", int'(ramwr_active), 0);
        chk("t6_we_in_reset", int'(wr_en), 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        send(1'b0, 8'h2C);
        send(1'b1, 8'h9A);
        send(1'b1, 8'hBC);
        idle(2);
        chk("t6_count", cap_a.size(), 1);
        if (cap_a.size() == 1) begin
            chk("t6_addr", int'(cap_a[0]), 0);
            chk("t6_data", int'(cap_d[0]), 16'h9ABC);
        end

        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
